// File: rtl/uart_rx_gpout.sv
// UART 8N1 receiver holding the last good byte on gpout; gpout[0] is the child-present flag.
// Optional link-loss timeout clearing gpout is enabled by defining CRIANCA_TIMEOUT_EN.
module uart_rx_gpout #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD           = 9600,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] gpout,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       crianca,
    output logic       link_ok
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          s1;
    logic          rs;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    idx;
    logic [2:0]    idx_n;
    logic [7:0]    shift;
    logic          samp;
    logic          load;
    logic          ferr;

    // two-stage synchronizer for the asynchronous line, idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            rs <= 1'b1;
        end else begin
            s1 <= rxd;
            rs <= s1;
        end
    end

    // FSM state, bit-period counter and bit index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    // next-state logic: mid-bit sampling, stop-bit check, break wait
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        samp    = 1'b0;
        load    = 1'b0;
        ferr    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rs) state_n = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rs ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    samp  = 1'b1;
                    if (idx == 3'd7) state_n = STOP;
                    else idx_n = idx + 3'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (rs) begin
                        load    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = BRK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BRK: begin
                if (rs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // data bits land LSB first at their mid-bit sample point
    always_ff @(posedge clk) begin
        if (rst) shift <= '0;
        else if (samp) shift[idx] <= rs;
    end

    // single-cycle status pulses, registered alongside the gpout update
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= load;
            frame_err <= ferr;
        end
    end

`ifdef CRIANCA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tcnt;
    logic          hit;

    assign hit = !load && (tcnt == TMAX - 1'b1);

    // link-loss timer, restarted by every good frame, saturating
    always_ff @(posedge clk) begin
        if (rst) tcnt <= '0;
        else if (load) tcnt <= '0;
        else if (tcnt != TMAX) tcnt <= tcnt + 1'b1;
    end

    // command register: new byte wins over the timeout clear
    always_ff @(posedge clk) begin
        if (rst) gpout <= '0;
        else if (load) gpout <= shift;
        else if (hit) gpout <= '0;
    end

    // link alive from the cycle after a good frame until timeout
    always_ff @(posedge clk) begin
        if (rst) link_ok <= 1'b0;
        else if (rx_valid) link_ok <= 1'b1;
        else if (hit) link_ok <= 1'b0;
    end
`else
    // command register holds the last good byte indefinitely
    always_ff @(posedge clk) begin
        if (rst) gpout <= '0;
        else if (load) gpout <= shift;
    end

    assign link_ok = 1'b1;
`endif

    assign crianca = gpout[0];

endmodule
